l2_arbiter: RTL and testbench

L2_ARBITER -- requirements
Module: l2_arbiter

---
 rtl/l2_arbiter.sv | 124 ++++++++++++
 tb/tb_l2_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 port between the instruction and data L1 miss paths.
// Round-robin on ties, one outstanding transaction at a time, and the L2 request
// is driven only from values captured at grant so it cannot move mid-transaction.
module l2_arbiter #(
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,
    // instruction side (read-only)
    input  logic [31:0]       i_address,
    input  logic              i_read,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    // data side (read or writeback)
    input  logic [31:0]       d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    // L2 port
    output logic [31:0]       l2_address,
    output logic              l2_read,
    output logic              l2_write,
    output logic [s_line-1:0] l2_wdata,
    output logic [7:0]        l2_byte_enable,
    input  logic [s_line-1:0] l2_rdata,
    input  logic              l2_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_d;      // 1: data side was served last, so I wins the next tie
    logic              i_pend;
    logic              d_pend;
    logic              grant_i;
    logic              grant_d;
    logic [31:0]       addr_q;
    logic [s_line-1:0] wdata_q;
    logic              read_q;
    logic              write_q;

    assign i_pend = i_read;
    assign d_pend = d_read | d_write;

    // Next-state and grant decision; grants are only issued from IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_pend && (!d_pend || last_d)) begin
                    grant_i    = 1'b1;
                    state_next = SERVE_I;
                end else if (d_pend) begin
                    grant_d    = 1'b1;
                    state_next = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Round-robin history, updated only when a transaction completes.
    always_ff @(posedge clk) begin
        if (rst)                            last_d <= 1'b1;
        else if (state == SERVE_I && l2_resp) last_d <= 1'b0;
        else if (state == SERVE_D && l2_resp) last_d <= 1'b1;
    end

    // Request latches: captured on grant, strobes dropped on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else if (grant_i) begin
            addr_q  <= i_address;
            read_q  <= 1'b1;
            write_q <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= d_address;
            wdata_q <= d_wdata;
            // read and write together count as a write
            read_q  <= ~d_write;
            write_q <= d_write;
        end else if (state != IDLE && l2_resp) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end
    end

    assign l2_address     = addr_q;
    assign l2_wdata       = wdata_q;
    assign l2_read        = read_q;
    assign l2_write       = write_q;
    assign l2_byte_enable = 8'hFF;

    // Completion is steered to the side being served; line data goes to both.
    assign i_resp  = (state == SERVE_I) & l2_resp;
    assign d_resp  = (state == SERVE_D) & l2_resp;
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed scenarios plus random traffic, compared each cycle
// against a transaction-level model of the arbiter.
module tb_l2_arbiter;

    localparam int S_LINE = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       i_address;
    logic              i_read;
    logic [S_LINE-1:0] i_rdata;
    logic              i_resp;
    logic [31:0]       d_address;
    logic              d_read;
    logic              d_write;
    logic [S_LINE-1:0] d_wdata;
    logic [S_LINE-1:0] d_rdata;
    logic              d_resp;
    logic [31:0]       l2_address;
    logic              l2_read;
    logic              l2_write;
    logic [S_LINE-1:0] l2_wdata;
    logic [7:0]        l2_byte_enable;
    logic [S_LINE-1:0] l2_rdata;
    logic              l2_resp;

    l2_arbiter #(.s_line(S_LINE)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_address      (i_address),
        .i_read         (i_read),
        .i_rdata        (i_rdata),
        .i_resp         (i_resp),
        .d_address      (d_address),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_resp         (d_resp),
        .l2_address     (l2_address),
        .l2_read        (l2_read),
        .l2_write       (l2_write),
        .l2_wdata       (l2_wdata),
        .l2_byte_enable (l2_byte_enable),
        .l2_rdata       (l2_rdata),
        .l2_resp        (l2_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding transaction record plus fairness history.
    typedef struct {
        bit                is_d;
        bit                wr;
        logic [31:0]       addr;
        logic [S_LINE-1:0] wdata;
    } txn_t;

    txn_t        cur;
    bit          busy       = 1'b0;
    bit          last_was_d = 1'b1;
    bit          model_ok   = 1'b0;
    logic        prev_strobe = 1'b0;
    logic [31:0] starts[$];

    task automatic check(input string tag, input logic [S_LINE-1:0] got, input logic [S_LINE-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs against the model, and log the address of each new L2 request.
    task automatic check_outputs();
        if (!model_ok) return;
        check("l2_read",  l2_read,  busy & ~cur.wr);
        check("l2_write", l2_write, busy & cur.wr);
        check("l2_address", l2_address, cur.addr);
        check("l2_wdata", l2_wdata, cur.wdata);
        check("l2_byte_enable", l2_byte_enable, 8'hFF);
        check("i_resp", i_resp, busy & ~cur.is_d & l2_resp);
        check("d_resp", d_resp, busy & cur.is_d & l2_resp);
        check("i_rdata", i_rdata, l2_rdata);
        check("d_rdata", d_rdata, l2_rdata);
        if ((l2_read | l2_write) && !prev_strobe) starts.push_back(l2_address);
        prev_strobe = l2_read | l2_write;
    endtask

    // Apply the arbitration rules for one rising edge using the inputs driven this cycle.
    task automatic model_edge();
        bit ip, dp, pick_d;
        if (rst) begin
            busy       = 1'b0;
            last_was_d = 1'b1;
            cur.is_d   = 1'b0;
            cur.wr     = 1'b0;
            cur.addr   = '0;
            cur.wdata  = '0;
            model_ok   = 1'b1;
        end else if (busy) begin
            if (l2_resp) begin
                busy       = 1'b0;
                last_was_d = cur.is_d;
            end
        end else begin
            ip = i_read;
            dp = d_read | d_write;
            if (ip || dp) begin
                pick_d   = dp && (!ip || !last_was_d);
                busy     = 1'b1;
                cur.is_d = pick_d;
                cur.wr   = pick_d && d_write;
                cur.addr = pick_d ? d_address : i_address;
                if (pick_d) cur.wdata = d_wdata;
            end
        end
    endtask

    // One clock: check at negedge+1, advance model at posedge, return at next negedge.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        l2_resp = 1'b0;
    endtask

    logic [S_LINE-1:0] line_a;
    logic [S_LINE-1:0] line_w;
    logic [31:0]       exp_seq[4];

    initial begin
        rst       = 1'b1;
        i_address = '0;
        d_address = '0;
        d_wdata   = '0;
        l2_rdata  = '0;
        idle_inputs();
        @(negedge clk);
        tick();
        rst = 1'b0;
        tick();   // reset state checked here

        // Instruction read, response after three wait cycles.
        line_a    = {8{32'hA5A5_0001}};
        i_address = 32'h0000_1040;
        i_read    = 1'b1;
        tick();
        i_read = 1'b0;
        tick(); tick(); tick();
        l2_rdata = line_a;
        l2_resp  = 1'b1;
        tick();
        l2_resp = 1'b0;
        tick();

        // Data writeback; address changed mid-wait must not reach L2.
        line_w    = {8{32'hDEAD_BEEF}};
        d_address = 32'h8000_0020;
        d_wdata   = line_w;
        d_write   = 1'b1;
        tick();
        d_write   = 1'b0;
        d_address = 32'h0;
        d_wdata   = '0;
        tick(); tick();
        l2_resp = 1'b1;
        tick();
        l2_resp = 1'b0;
        tick();

        // Read and write together count as a write.
        d_address = 32'h0000_3000;
        d_read    = 1'b1;
        d_write   = 1'b1;
        tick();
        idle_inputs();
        l2_resp = 1'b1;
        tick();
        l2_resp = 1'b0;
        tick();

        // Both sides held high after reset: grants alternate I, D, I, D.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        i_address = 32'h0000_0100;
        d_address = 32'h0000_0200;
        i_read    = 1'b1;
        d_read    = 1'b1;
        starts.delete();
        for (int c = 0; c < 24; c++) begin
            l2_resp = (c % 3 == 2);
            tick();
        end
        idle_inputs();
        tick(); tick();
        exp_seq = '{32'h100, 32'h200, 32'h100, 32'h200};
        check("grant_count_ge4", (starts.size() >= 4), 1'b1);
        for (int k = 0; k < 4; k++)
            check($sformatf("grant_order_%0d", k), (k < starts.size()) ? starts[k] : 32'hFFFF_FFFF, exp_seq[k]);

        // Reset two cycles into an instruction fetch, then a stray response.
        i_address = 32'h0000_5500;
        i_read    = 1'b1;
        tick();
        i_read = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        l2_resp = 1'b1;
        tick();
        l2_resp = 1'b0;
        tick(); tick();

        // Response pulse with nothing pending.
        l2_resp = 1'b1;
        tick();
        l2_resp = 1'b0;
        tick();

        // Random traffic, including occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            i_read    = ($urandom_range(0, 2) == 0);
            d_read    = ($urandom_range(0, 3) == 0);
            d_write   = ($urandom_range(0, 3) == 0);
            i_address = $urandom;
            d_address = $urandom;
            for (int w = 0; w < S_LINE / 32; w++) begin
                d_wdata[w*32 +: 32]  = $urandom;
                l2_rdata[w*32 +: 32] = $urandom;
            end
            l2_resp = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
